// File: rtl/jt12_slot_acc_pkg.sv
// jt12_slot_acc_pkg: shared widths, slot-group encoding, carrier table and clip limits
// for the slot accumulator.
package jt12_slot_acc_pkg;

   localparam int NUM_CH_DEF = 6;
   localparam int ACC_W_DEF  = 11;
   localparam int MIX_W_DEF  = 12;

   localparam logic signed [8:0] CLIP_MAX = 9'sd255;
   localparam logic signed [8:0] CLIP_MIN = -9'sd256;

   typedef enum logic [2:0] {
      GRP_NONE = 3'd0,
      GRP_S1   = 3'd1,
      GRP_S3   = 3'd2,
      GRP_S2   = 3'd3,
      GRP_S4   = 3'd4
   } grp_e;

   // Bit order {S1, S2, S3, S4}; indexed by algorithm.
   localparam logic [3:0] CAR_MASK [8] = '{
      4'b0001, 4'b0001, 4'b0001, 4'b0001,
      4'b0101, 4'b0111, 4'b0111, 4'b1111
   };

   function automatic logic is_carrier(input logic [2:0] alg, input grp_e g);
      logic [3:0] m;
      m = CAR_MASK[alg];
      return g == GRP_S1 ? m[3] :
             g == GRP_S2 ? m[2] :
             g == GRP_S3 ? m[1] :
             g == GRP_S4 ? m[0] : 1'b0;
   endfunction

endpackage

// File: rtl/jt12_sh.sv
// jt12_sh: clock-enabled shift register of `stages` words of `width` bits;
// drop is the word written `stages` enabled cycles earlier.
module jt12_sh #(
   parameter int width  = 5,
   parameter int stages = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cen,
   input  logic [width-1:0] din,
   output logic [width-1:0] drop
);

   logic [width-1:0] r_bits [stages];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < stages; i++) r_bits[i] <= '0;
      end else if (cen) begin
         r_bits[0] <= din;
         for (int i = 1; i < stages; i++) r_bits[i] <= r_bits[i-1];
      end
   end

   assign drop = r_bits[stages-1];

endmodule

// File: rtl/jt12_slot_acc.sv
// jt12_slot_acc: sums carrier operators per channel, clips to 9 bits and pans/mixes
// the channels into one stereo sample per frame. Optional DAC override: JT12_DAC_EN.
module jt12_slot_acc
   import jt12_slot_acc_pkg::*;
#(
   parameter int NUM_CH = NUM_CH_DEF,
   parameter int ACC_W  = ACC_W_DEF,
   parameter int MIX_W  = MIX_W_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clk_en,
   input  logic                    zero,
   input  logic                    s1_enters,
   input  logic                    s3_enters,
   input  logic                    s2_enters,
   input  logic                    s4_enters,
   input  logic signed [8:0]       op_result,
   input  logic [2:0]              alg,
   input  logic [1:0]              rl,
`ifdef JT12_DAC_EN
   input  logic                    dac_en,
   input  logic signed [8:0]       dac_val,
`endif
   output logic signed [MIX_W-1:0] left,
   output logic signed [MIX_W-1:0] right,
   output logic                    sample
);

   localparam int CW = $clog2(NUM_CH);

   logic [CW-1:0]           r_ch;
   logic [CW-1:0]           w_ch;
   logic [CW-1:0]           w_ch_nx;
   grp_e                    w_grp;
   logic                    w_first;
   logic                    w_last;
   logic                    w_done;
   logic signed [ACC_W-1:0] w_contrib;
   logic signed [ACC_W-1:0] w_acc;
   logic signed [ACC_W-1:0] w_acc_nx;
   logic signed [ACC_W-1:0] w_sum;
   logic signed [8:0]       w_clip;
   logic signed [8:0]       w_mix_in;
   logic signed [MIX_W-1:0] w_mix_ext;
   logic signed [MIX_W-1:0] r_lmix;
   logic signed [MIX_W-1:0] r_rmix;
   logic signed [MIX_W-1:0] w_lmix;
   logic signed [MIX_W-1:0] w_rmix;

   // The ring output is the same channel's partial sum from the previous group.
   jt12_sh #(.width(ACC_W), .stages(NUM_CH)) u_acc (
      .clk  (clk),
      .rst  (rst),
      .cen  (clk_en),
      .din  (w_acc_nx),
      .drop (w_acc)
   );

   always_comb begin
      w_ch      = zero ? '0 : r_ch;
      w_ch_nx   = zero ? CW'(1) : (r_ch == CW'(NUM_CH-1) ? '0 : r_ch + 1'b1);
      w_grp     = s2_enters ? GRP_S1 : s4_enters ? GRP_S3 :
                  s1_enters ? GRP_S2 : s3_enters ? GRP_S4 : GRP_NONE;
      w_first   = w_ch == '0;
      w_last    = w_ch == CW'(NUM_CH-1);
      w_done    = w_grp == GRP_S4 && w_last;
      w_contrib = is_carrier(alg, w_grp) ? {{(ACC_W-9){op_result[8]}}, op_result} : '0;
      w_sum     = w_acc + w_contrib;
      w_acc_nx  = w_grp == GRP_S1 ? w_contrib : w_grp == GRP_NONE ? w_acc : w_sum;
      w_clip    = w_sum > ACC_W'(CLIP_MAX) ? CLIP_MAX :
                  w_sum < ACC_W'(CLIP_MIN) ? CLIP_MIN : w_sum[8:0];
`ifdef JT12_DAC_EN
      w_mix_in  = (dac_en && w_last) ? dac_val : w_clip;
`else
      w_mix_in  = w_clip;
`endif
      w_mix_ext = {{(MIX_W-9){w_mix_in[8]}}, w_mix_in};
      w_lmix    = (w_first ? '0 : r_lmix) + (rl[1] ? w_mix_ext : '0);
      w_rmix    = (w_first ? '0 : r_rmix) + (rl[0] ? w_mix_ext : '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ch   <= '0;
         r_lmix <= '0;
         r_rmix <= '0;
         left   <= '0;
         right  <= '0;
         sample <= 1'b0;
      end else if (clk_en) begin
         r_ch   <= w_ch_nx;
         sample <= w_done;
         if (w_grp == GRP_S4) begin
            r_lmix <= w_lmix;
            r_rmix <= w_rmix;
         end
         if (w_done) begin
            left  <= w_lmix;
            right <= w_rmix;
         end
      end
   end

endmodule

// File: tb/tb_jt12_slot_acc.sv
// tb_jt12_slot_acc: directed and random frames checked against a per-frame
// arithmetic model of carrier sums, clipping and panning.
module tb_jt12_slot_acc;

   logic               clk = 1'b0;
   logic               rst, clk_en, zero;
   logic               s1_enters, s3_enters, s2_enters, s4_enters;
   logic signed [8:0]  op_result;
   logic [2:0]         alg;
   logic [1:0]         rl;
   logic signed [11:0] left, right;
   logic               sample;
`ifdef JT12_DAC_EN
   logic               dac_en;
   logic signed [8:0]  dac_val;
`endif

   jt12_slot_acc dut (
      .clk       (clk),
      .rst       (rst),
      .clk_en    (clk_en),
      .zero      (zero),
      .s1_enters (s1_enters),
      .s3_enters (s3_enters),
      .s2_enters (s2_enters),
      .s4_enters (s4_enters),
      .op_result (op_result),
      .alg       (alg),
      .rl        (rl),
`ifdef JT12_DAC_EN
      .dac_en    (dac_en),
      .dac_val   (dac_val),
`endif
      .left      (left),
      .right     (right),
      .sample    (sample)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   // Frame description: f_op[operator 0..3 = S1..S4][channel]
   int f_op [4][6];
   int f_alg [6];
   int f_rl [6];
   int f_dac_en = 0;
   int f_dac_val = 0;
   int exp_l = 0;
   int exp_r = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic bit carrier(input int a, input int oi);
      if (oi == 3) return 1'b1;
      if (oi == 1) return a >= 4;
      if (oi == 2) return a >= 5;
      return a == 7;
   endfunction

   task automatic model(output int ml, output int mr);
      int s;
      ml = 0;
      mr = 0;
      for (int c = 0; c < 6; c++) begin
         s = 0;
         for (int o = 0; o < 4; o++) if (carrier(f_alg[c], o)) s += f_op[o][c];
         if (s > 255) s = 255;
         if (s < -256) s = -256;
         if (c == 5 && f_dac_en != 0) s = f_dac_val;
         if (f_rl[c] >= 2) ml += s;
         if (f_rl[c] % 2 == 1) mr += s;
      end
   endtask

   task automatic clear_frame();
      for (int c = 0; c < 6; c++) begin
         f_alg[c] = 0;
         f_rl[c] = 0;
         for (int o = 0; o < 4; o++) f_op[o][c] = 0;
      end
      f_dac_en = 0;
   endtask

   task automatic rand_frame();
      for (int c = 0; c < 6; c++) begin
         f_alg[c] = int'($urandom_range(0, 7));
         f_rl[c] = int'($urandom_range(0, 3));
         for (int o = 0; o < 4; o++) f_op[o][c] = int'($urandom_range(0, 511)) - 256;
      end
      f_dac_en = 0;
   endtask

   // Slot position g in transmission order S1,S3,S2,S4.
   task automatic slot(input int g, input int c);
      int oi;
      oi = (g == 0) ? 0 : (g == 1) ? 2 : (g == 2) ? 1 : 3;
      zero      = (g == 0 && c == 0);
      s2_enters = (oi == 0);
      s1_enters = (oi == 1);
      s4_enters = (oi == 2);
      s3_enters = (oi == 3);
      op_result = 9'(f_op[oi][c]);
      alg       = 3'(f_alg[c]);
      rl        = 2'(f_rl[c]);
`ifdef JT12_DAC_EN
      dac_en    = (f_dac_en != 0 && oi == 3 && c == 5);
      dac_val   = 9'(f_dac_val);
`endif
      clk_en = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic stall();
      clk_en = 1'b0;
      repeat (10) begin
         zero      = 1'($urandom_range(0, 1));
         s1_enters = 1'($urandom_range(0, 1));
         s2_enters = 1'($urandom_range(0, 1));
         s3_enters = 1'($urandom_range(0, 1));
         s4_enters = 1'($urandom_range(0, 1));
         op_result = 9'($urandom_range(0, 511));
         alg       = 3'($urandom_range(0, 7));
         rl        = 2'($urandom_range(0, 3));
         @(posedge clk);
         #1;
      end
      chk("stall_left", int'(left), exp_l);
      chk("stall_right", int'(right), exp_r);
      chk("stall_sample", int'(sample), 0);
   endtask

   task automatic run_frame(input string tag, input int stall_at);
      int ml, mr, any;
      model(ml, mr);
      any = 0;
      for (int g = 0; g < 4; g++)
         for (int c = 0; c < 6; c++) begin
            slot(g, c);
            if (g * 6 + c == stall_at) stall();
            if (g * 6 + c < 23 && sample) any = 1;
         end
      chk({tag, "_early_sample"}, any, 0);
      chk({tag, "_sample"}, int'(sample), 1);
      chk({tag, "_left"}, int'(left), ml);
      chk({tag, "_right"}, int'(right), mr);
      exp_l = ml;
      exp_r = mr;
   endtask

   initial begin
      rst = 1'b1;
      clk_en = 1'b0;
      zero = 1'b0;
      s1_enters = 1'b0;
      s2_enters = 1'b0;
      s3_enters = 1'b0;
      s4_enters = 1'b0;
      op_result = '0;
      alg = '0;
      rl = '0;
`ifdef JT12_DAC_EN
      dac_en = 1'b0;
      dac_val = '0;
`endif
      clear_frame();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("reset_left", int'(left), 0);
      chk("reset_right", int'(right), 0);
      chk("reset_sample", int'(sample), 0);

      // ch0 all +100 under alg 7: 400 clips to 255
      clear_frame();
      for (int o = 0; o < 4; o++) f_op[o][0] = 100;
      for (int c = 0; c < 6; c++) begin
         f_alg[c] = 7;
         f_rl[c] = 3;
      end
      run_frame("clip_pos", -1);
      chk("clip_pos_val", int'(left), 255);
      run_frame("clip_pos2", -1);

      // alg 0: only S4 counts
      clear_frame();
      f_op[0][0] = 200;
      f_op[3][0] = -50;
      f_rl[0] = 2;
      run_frame("alg0", -1);
      chk("alg0_val", int'(left), -50);

      // alg 4 everywhere: -400 per channel clips to -256
      clear_frame();
      for (int c = 0; c < 6; c++) begin
         f_alg[c] = 4;
         f_rl[c] = 1;
         f_op[1][c] = -200;
         f_op[3][c] = -200;
         f_op[0][c] = 123;
         f_op[2][c] = -77;
      end
      run_frame("clip_neg", -1);
      chk("clip_neg_val", int'(right), -1536);

      for (int n = 0; n < 30; n++) begin
         rand_frame();
         run_frame("rand", (n % 3 == 0) ? int'($urandom_range(0, 22)) : -1);
      end

      // Reset in the middle of a frame with nonzero sums in flight
      rand_frame();
      for (int g = 0; g < 2; g++)
         for (int c = 0; c < 5; c++) slot(g, c);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("midrst_left", int'(left), 0);
      chk("midrst_right", int'(right), 0);
      chk("midrst_sample", int'(sample), 0);
      exp_l = 0;
      exp_r = 0;
      rand_frame();
      run_frame("post_rst", 7);

`ifdef JT12_DAC_EN
      clear_frame();
      for (int c = 0; c < 6; c++) begin
         f_alg[c] = 7;
         f_rl[c] = 3;
      end
      for (int o = 0; o < 4; o++) f_op[o][5] = 50;
      f_dac_en = 1;
      f_dac_val = -7;
      run_frame("dac", -1);
      chk("dac_val", int'(left), -7);
      rand_frame();
      f_dac_en = 1;
      f_dac_val = int'($urandom_range(0, 511)) - 256;
      run_frame("dac_rand", -1);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
